// File: rtl/pipeline_stall_ctrl.sv
// Load-use / mul-div stall and flush controller for the RV32IM pipeline.
// Optional macro STALL_PERF_CNT_EN adds 32-bit stall/flush performance counters.
module pipeline_stall_ctrl #(
    parameter int MAX_MD_CYCLES = 40,
    parameter int CNT_W         = 6
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BUBBLE,
    input  logic [1:0] FRWD_RS1_WB,
    input  logic [1:0] FRWD_RS2_WB,
    input  logic       FORWARD_MEMORY,
    input  logic       MD_START,
    input  logic       MD_DONE,
    input  logic       BRANCH_TAKEN,
    output logic       PC_WRITE,
    output logic       IFID_WRITE,
    output logic       IFID_FLUSH,
    output logic       IDEX_WRITE,
    output logic       IDEX_FLUSH,
    output logic       EXMEM_FLUSH,
    output logic [1:0] FRWD_RS1_SEL,
    output logic [1:0] FRWD_RS2_SEL,
    output logic       FORWARD_MEMORY_Q,
    output logic       MD_TIMEOUT
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] LOAD_STALL_CNT,
    output logic [31:0] MD_STALL_CNT,
    output logic [31:0] FLUSH_CNT
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REPLAY   = 2'd1,
        ST_MD_STALL = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_md_cnt;
    logic [CNT_W-1:0] w_md_cnt_nxt;
    logic [1:0]       r_rs1_sel;
    logic [1:0]       r_rs2_sel;
    logic [1:0]       w_rs1_sel_nxt;
    logic [1:0]       w_rs2_sel_nxt;
    logic             r_fwd_mem;
    logic             w_fwd_mem_nxt;
    logic             r_md_timeout;
    logic             w_md_timeout_nxt;
    logic             w_branch_hon;
    logic             w_load_stall;
    logic             w_md_cycle;

    always_comb begin
        w_state_nxt      = r_state;
        w_md_cnt_nxt     = r_md_cnt;
        w_rs1_sel_nxt    = FRWD_RS1_WB;
        w_rs2_sel_nxt    = FRWD_RS2_WB;
        w_fwd_mem_nxt    = FORWARD_MEMORY;
        w_md_timeout_nxt = r_md_timeout;
        w_branch_hon     = 1'b0;
        w_load_stall     = 1'b0;
        w_md_cycle       = 1'b0;
        PC_WRITE         = 1'b1;
        IFID_WRITE       = 1'b1;
        IDEX_WRITE       = 1'b1;
        IFID_FLUSH       = 1'b0;
        IDEX_FLUSH       = 1'b0;
        EXMEM_FLUSH      = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (BRANCH_TAKEN) begin
                    w_branch_hon  = 1'b1;
                    IFID_FLUSH    = 1'b1;
                    IDEX_FLUSH    = 1'b1;
                    w_rs1_sel_nxt = 2'b00;
                    w_rs2_sel_nxt = 2'b00;
                    w_fwd_mem_nxt = 1'b0;
                end else if (MD_START && !MD_DONE) begin
                    PC_WRITE      = 1'b0;
                    IFID_WRITE    = 1'b0;
                    IDEX_WRITE    = 1'b0;
                    EXMEM_FLUSH   = 1'b1;
                    w_md_cnt_nxt  = '0;
                    w_rs1_sel_nxt = r_rs1_sel;
                    w_rs2_sel_nxt = r_rs2_sel;
                    w_fwd_mem_nxt = r_fwd_mem;
                    w_state_nxt   = ST_MD_STALL;
                end else if (BUBBLE) begin
                    PC_WRITE     = 1'b0;
                    IFID_WRITE   = 1'b0;
                    IDEX_FLUSH   = 1'b1;
                    w_load_stall = 1'b1;
                    w_state_nxt  = ST_REPLAY;
                end
            end
            ST_REPLAY: begin
                if (BRANCH_TAKEN) begin
                    w_branch_hon  = 1'b1;
                    IFID_FLUSH    = 1'b1;
                    IDEX_FLUSH    = 1'b1;
                    w_rs1_sel_nxt = 2'b00;
                    w_rs2_sel_nxt = 2'b00;
                    w_fwd_mem_nxt = 1'b0;
                end
                w_state_nxt = ST_RUN;
            end
            ST_MD_STALL: begin
                w_md_cycle    = 1'b1;
                w_rs1_sel_nxt = r_rs1_sel;
                w_rs2_sel_nxt = r_rs2_sel;
                w_fwd_mem_nxt = r_fwd_mem;
                if (r_md_cnt != {CNT_W{1'b1}}) begin
                    w_md_cnt_nxt = r_md_cnt + 1'b1;
                end
                if (MD_DONE) begin
                    w_state_nxt = ST_RUN;
                end else if (r_md_cnt == CNT_W'(MAX_MD_CYCLES - 1)) begin
                    // Watchdog: release the pipeline as if the unit had finished.
                    w_md_timeout_nxt = 1'b1;
                    w_state_nxt      = ST_RUN;
                end else begin
                    PC_WRITE    = 1'b0;
                    IFID_WRITE  = 1'b0;
                    IDEX_WRITE  = 1'b0;
                    EXMEM_FLUSH = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        if (RESET) begin
            PC_WRITE    = 1'b0;
            IFID_WRITE  = 1'b0;
            IDEX_WRITE  = 1'b0;
            IFID_FLUSH  = 1'b1;
            IDEX_FLUSH  = 1'b1;
            EXMEM_FLUSH = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= ST_RUN;
            r_md_cnt     <= '0;
            r_rs1_sel    <= 2'b00;
            r_rs2_sel    <= 2'b00;
            r_fwd_mem    <= 1'b0;
            r_md_timeout <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_md_cnt     <= w_md_cnt_nxt;
            r_rs1_sel    <= w_rs1_sel_nxt;
            r_rs2_sel    <= w_rs2_sel_nxt;
            r_fwd_mem    <= w_fwd_mem_nxt;
            r_md_timeout <= w_md_timeout_nxt;
        end
    end

    assign FRWD_RS1_SEL     = r_rs1_sel;
    assign FRWD_RS2_SEL     = r_rs2_sel;
    assign FORWARD_MEMORY_Q = r_fwd_mem;
    assign MD_TIMEOUT       = r_md_timeout;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] r_load_stall_cnt;
    logic [31:0] r_md_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_load_stall_cnt <= '0;
            r_md_stall_cnt   <= '0;
            r_flush_cnt      <= '0;
        end else begin
            if (w_load_stall) r_load_stall_cnt <= r_load_stall_cnt + 32'd1;
            if (w_md_cycle)   r_md_stall_cnt   <= r_md_stall_cnt + 32'd1;
            if (w_branch_hon) r_flush_cnt      <= r_flush_cnt + 32'd1;
        end
    end

    assign LOAD_STALL_CNT = r_load_stall_cnt;
    assign MD_STALL_CNT   = r_md_stall_cnt;
    assign FLUSH_CNT      = r_flush_cnt;
`endif

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Consumer side of the load-use hazard interface. Takes BUBBLE/FRWD/FORWARD_MEMORY requests from the hazard detector, plus mul/div busy and branch-taken events. Drives the PC and pipeline-register write/flush controls. Holds the WB-forwarding selects across the stall so they apply on the replay cycle. Sits between the hazard units and the IF/ID, ID/EX and EX/MEM registers of the RV32IM pipeline.

Parameters:
MAX_MD_CYCLES, 40, watchdog limit on consecutive mul/div stall cycles (range 2..63).
CNT_W, 6, width of the mul/div stall counter.

Ports:
CLK  in  1  pipeline clock, rising edge
RESET  in  1  asynchronous active-high reset
BUBBLE  in  1  load-use stall request from the hazard detector (ID stage)
FRWD_RS1_WB  in  2  RS1 forwarding select from the hazard detector
FRWD_RS2_WB  in  2  RS2 forwarding select from the hazard detector
FORWARD_MEMORY  in  1  store-data forward request from the hazard detector
MD_START  in  1  mul/div op entering EX needs multi-cycle execution
MD_DONE  in  1  mul/div result valid this cycle
BRANCH_TAKEN  in  1  branch/jump resolved taken in EX
PC_WRITE  out  1  PC register enable
IFID_WRITE  out  1  IF/ID register enable
IFID_FLUSH  out  1  clear IF/ID to NOP
IDEX_WRITE  out  1  ID/EX register enable
IDEX_FLUSH  out  1  load NOP into ID/EX
EXMEM_FLUSH  out  1  load NOP into EX/MEM
FRWD_RS1_SEL  out  2  registered RS1 forwarding select for EX
FRWD_RS2_SEL  out  2  registered RS2 forwarding select for EX
FORWARD_MEMORY_Q  out  1  registered store-data forward for MEM
MD_TIMEOUT  out  1  sticky watchdog flag

Behaviour:
- States: RUN, REPLAY, MD_STALL. Reset (async) enters RUN.
- While RESET=1:
  - PC_WRITE, IFID_WRITE and IDEX_WRITE are 0.
  - IFID_FLUSH, IDEX_FLUSH and EXMEM_FLUSH are 1.
  - FRWD_*_SEL=00, FORWARD_MEMORY_Q=0, MD_TIMEOUT=0, counter=0.
- Control outputs are combinational from state and inputs. FRWD_*_SEL and FORWARD_MEMORY_Q are registered.
- Priority in RUN: BRANCH_TAKEN > MD_START > BUBBLE.
- RUN, no event: all writes 1, all flushes 0. FRWD_*_SEL and FORWARD_MEMORY_Q take the inputs at the next edge (1-cycle latency).
- RUN, BRANCH_TAKEN=1:
  - PC_WRITE=1, IFID_FLUSH=1, IDEX_FLUSH=1.
  - Any simultaneous BUBBLE or MD_START is discarded.
  - Next FRWD_*_SEL=00 and FORWARD_MEMORY_Q=0. Stay in RUN.
- RUN, MD_START=1 and MD_DONE=0:
  - PC_WRITE=IFID_WRITE=IDEX_WRITE=0, EXMEM_FLUSH=1, counter cleared.
  - Go to MD_STALL.
- RUN, MD_START=1 and MD_DONE=1: single-cycle op, treated as no event.
- RUN, BUBBLE=1 (no higher event):
  - PC_WRITE=0, IFID_WRITE=0, IDEX_WRITE=1, IDEX_FLUSH=1.
  - Latch FRWD_RS1_WB and FRWD_RS2_WB into the SEL registers. Go to REPLAY.
- REPLAY (exactly 1 cycle):
  - All writes 1, flushes 0. The latched FRWD_*_SEL values are presented this cycle.
  - BUBBLE and MD_START inputs are ignored.
  - BRANCH_TAKEN acts as in RUN and clears the SEL registers.
  - Next state RUN; SEL registers reload from the inputs.
- MD_STALL:
  - PC_WRITE=IFID_WRITE=IDEX_WRITE=0, EXMEM_FLUSH=1. FRWD_*_SEL and FORWARD_MEMORY_Q hold.
  - BRANCH_TAKEN and BUBBLE are ignored.
  - Counter increments each cycle, saturating at 2^CNT_W-1.
- Leaving MD_STALL on MD_DONE=1:
  - That same cycle: writes 1, EXMEM_FLUSH=0.
  - Next state RUN.
- Leaving MD_STALL on watchdog: if MD_DONE=0 when counter==MAX_MD_CYCLES-1, set MD_TIMEOUT (cleared only by RESET), behave as if MD_DONE, and return to RUN.
- RESET asserted mid-stall: immediate return to the reset output values; pending latched selects are lost.

Optional Feature:
STALL_PERF_CNT_EN:
- Defined: adds 32-bit outputs LOAD_STALL_CNT, MD_STALL_CNT and FLUSH_CNT.
  - LOAD_STALL_CNT increments on each RUN-to-REPLAY transition.
  - MD_STALL_CNT increments on each MD_STALL cycle.
  - FLUSH_CNT increments on each cycle with BRANCH_TAKEN honoured.
  - All three wrap at 2^32, reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset: RESET=1 mid-run → PC_WRITE=0, all three flushes 1, selects 00. Release → next cycle PC_WRITE=1, flushes 0.
- Load-use: BUBBLE=1, FRWD_RS1_WB=01, FRWD_RS2_WB=00 for 1 cycle, then BUBBLE=0.
  - Cycle 0: PC_WRITE=0, IFID_WRITE=0, IDEX_FLUSH=1.
  - Cycle 1 (REPLAY): FRWD_RS1_SEL=01, FRWD_RS2_SEL=00, all writes 1.
- Branch beats bubble: BRANCH_TAKEN=1 and BUBBLE=1 in the same cycle → PC_WRITE=1, IFID_FLUSH=1, IDEX_FLUSH=1, no REPLAY, next selects 00.
- Mul/div: MD_START=1, MD_DONE after 5 cycles → PC_WRITE=0 and EXMEM_FLUSH=1 for 5 cycles. PC_WRITE=1 on the MD_DONE cycle; BRANCH_TAKEN pulse during the stall has no effect.
- Watchdog: MAX_MD_CYCLES=4, MD_DONE held 0 → returns to RUN after 4 stall cycles, MD_TIMEOUT=1 and stays 1 until RESET.
- STALL_PERF_CNT_EN: 3 load-use stalls, one 5-cycle mul/div stall, 2 flushes → LOAD_STALL_CNT=3, MD_STALL_CNT=5, FLUSH_CNT=2.
